// File: rtl/tape_playback_reader.sv
// Reads the note tape back out of note memory and holds each byte on note_out
// for TICKS_PER_STEP cycles, stopping at END_CODE or the last address.
module tape_playback_reader #(
  parameter int              ADDR_W         = 10,
  parameter int              DATA_W         = 8,
  parameter int              TICKS_PER_STEP = 25000000,
  parameter logic [DATA_W-1:0] END_CODE     = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] note_out,
  output logic              note_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICKS_PER_STEP - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                rd_nxt;
  logic [DATA_W-1:0]   note_nxt;
  logic                nv_nxt;
  logic                done_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;

  assign mem_write_en = 1'b0;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read_en <= 1'b0;
      mem_addr    <= '0;
      note_out    <= '0;
      note_valid  <= 1'b0;
      done        <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      mem_read_en <= rd_nxt;
      mem_addr    <= addr_nxt;
      note_out    <= note_nxt;
      note_valid  <= nv_nxt;
      done        <= done_nxt;
      cnt         <= cnt_nxt;
    end
  end

  // Every output is registered, so this block computes the values for the next edge.
  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    rd_nxt    = 1'b0;
    note_nxt  = note_out;
    nv_nxt    = 1'b0;
    done_nxt  = 1'b0;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          addr_nxt  = '0;
          rd_nxt    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = CAPTURE;
      CAPTURE: begin
        if (mem_data == END_CODE) begin
          note_nxt  = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          note_nxt  = mem_data;
          nv_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (mem_addr == ADDR_LAST) begin
            note_nxt  = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            addr_nxt  = mem_addr + ADDR_W'(1);
            rd_nxt    = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort takes priority over whatever the active state decided; the old note is silenced.
    if (stop && state != IDLE) begin
      state_nxt = IDLE;
      addr_nxt  = mem_addr;
      rd_nxt    = 1'b0;
      note_nxt  = '0;
      nv_nxt    = 1'b0;
      done_nxt  = 1'b0;
      cnt_nxt   = cnt;
    end
  end

endmodule

// File: tb/tb_tape_playback_reader.sv
// Directed bench for tape_playback_reader with a synchronous-read note memory model.
module tb_tape_playback_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int TICKS  = 4;

  logic              clk = 1'b0;
  logic              rst, start, stop;
  logic              mem_read_en, mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] note_out;
  logic              note_valid, busy, done;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int tests = 0;
  int fails = 0;
  int wr_viol = 0, addr_viol = 0, data_viol = 0, pulse_viol = 0;

  tape_playback_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICKS_PER_STEP(TICKS), .END_CODE(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .note_out(note_out), .note_valid(note_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory: data appears the cycle after the read strobe.
  always @(posedge clk) if (mem_read_en) mem_data <= mem[mem_addr];

  // Protocol monitor, sampled just after each rising edge.
  logic              prev_rd = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0, rd_addr = '0;
  always @(posedge clk) begin
    #1;
    if (mem_write_en !== 1'b0) wr_viol++;
    if (prev_rd && mem_addr !== prev_addr) addr_viol++;
    if (note_valid && note_out !== mem[rd_addr]) data_viol++;
    if (note_valid && done) pulse_viol++;
    if (mem_read_en) rd_addr = mem_addr;
    prev_rd   = mem_read_en;
    prev_addr = mem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int                ed;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] note;
    logic              nv;
    logic              dn;
    logic              bsy;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int k, rd_cnt, nv_cnt, done_at, last_addr, wraps, cnt;
    logic [ADDR_W-1:0] pa;

    tbl = '{
      '{ 1, 1'b1, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1},
      '{ 2, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1},
      '{ 3, 1'b0, 10'd0, 8'h11, 1'b1, 1'b0, 1'b1},
      '{ 4, 1'b0, 10'd0, 8'h11, 1'b0, 1'b0, 1'b1},
      '{ 7, 1'b1, 10'd1, 8'h11, 1'b0, 1'b0, 1'b1},
      '{ 8, 1'b0, 10'd1, 8'h11, 1'b0, 1'b0, 1'b1},
      '{ 9, 1'b0, 10'd1, 8'h22, 1'b1, 1'b0, 1'b1},
      '{15, 1'b0, 10'd2, 8'h00, 1'b1, 1'b0, 1'b1},
      '{19, 1'b1, 10'd3, 8'h00, 1'b0, 1'b0, 1'b1},
      '{21, 1'b0, 10'd3, 8'h00, 1'b0, 1'b1, 1'b0},
      '{22, 1'b0, 10'd3, 8'h00, 1'b0, 1'b0, 1'b0}
    };
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'hFF;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'hFF;

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_outputs", {mem_read_en, mem_addr, note_out, note_valid, busy, done}, '0);

    // Basic playback, table driven against edges counted from the start edge.
    start = 1'b1;
    k = 0; rd_cnt = 0; nv_cnt = 0;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == 1) start = 1'b0;
      rd_cnt += int'(mem_read_en);
      nv_cnt += int'(note_valid);
      if (k < 11 && tbl[k].ed == e) begin
        check($sformatf("play_edge%0d", e),
              {tbl[k].rd ? 1'b0 : 1'b0, mem_read_en, mem_addr, note_out, note_valid, done, busy},
              {1'b0, tbl[k].rd, tbl[k].addr, tbl[k].note, tbl[k].nv, tbl[k].dn, tbl[k].bsy});
        k++;
      end
    end
    check("read_strobe_count", rd_cnt, 4);
    check("note_valid_count", nv_cnt, 3);

    // Reset mid-HOLD of the second note, then replay from address 0.
    start = 1'b1; tick(); start = 1'b0;
    for (int e = 2; e <= 10; e++) tick();
    check("pre_reset_addr", {busy, mem_addr}, {1'b1, 10'd1});
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("mid_reset_outputs", {mem_read_en, mem_addr, note_out, note_valid, busy, done}, '0);
    start = 1'b1; tick(); start = 1'b0;
    check("replay_fetch", {mem_read_en, mem_addr}, {1'b1, 10'd0});
    tick(); tick();
    check("replay_first_note", {note_valid, note_out}, {1'b1, 8'h11});
    rst = 1'b1; tick(); rst = 1'b0;

    // Start while busy is ignored; stop during the second HOLD aborts silently.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("start_while_busy", {mem_read_en, mem_addr, note_out}, {1'b1, 10'd1, 8'h11});
    tick(); tick(); tick();
    check("second_note", {busy, note_out}, {1'b1, 8'h22});
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_outputs", {note_out, busy, done, mem_read_en}, {8'h00, 1'b0, 1'b0, 1'b0});
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); cnt += int'(done) + int'(busy); end
    check("stop_quiet", cnt, 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("start_stop_idle", {busy, mem_read_en}, 2'b00);
    tick();
    check("start_stop_idle_after", {busy, mem_read_en}, 2'b00);

    // Full tape with no terminator: plays every address, ends after the last hold.
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'h01;
    start = 1'b1; tick(); start = 1'b0;
    nv_cnt = 0; done_at = -1; last_addr = 0; wraps = 0; pa = mem_addr;
    for (int e = 2; e <= 6200 && done_at < 0; e++) begin
      tick();
      nv_cnt += int'(note_valid);
      if (busy && pa != '0 && mem_addr == '0) wraps++;
      pa = mem_addr;
      if (done) begin done_at = e; last_addr = int'(mem_addr); end
    end
    check("full_note_valid_count", nv_cnt, 1024);
    check("full_done_edge", done_at, 6145);
    check("full_last_addr", last_addr, 1023);
    check("full_no_wrap", wraps, 0);
    check("full_end_silent", {note_out, busy}, 9'd0);

    check("write_en_never", wr_viol, 0);
    check("addr_stable_on_read", addr_viol, 0);
    check("note_matches_read", data_viol, 0);
    check("valid_done_exclusive", pulse_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tape_playback_reader.md
Name: tape_playback_reader

Overview:
- Playback sequencer that reads the stored note tape back out of the 8-bit x 1024 note memory.
- Issues single-cycle reads and captures each byte in the cycle after the read strobe; write enable is held low throughout.
- Holds each note on note_out for a fixed number of clock ticks, then steps to the next address.
- Sits between the note memory and the tone generator; the tone generator consumes note_out directly.

Parameters:
ADDR_W, 10, memory address width (depth 2^ADDR_W)
DATA_W, 8, note byte width
TICKS_PER_STEP, 25000000, clk cycles each note is held in HOLD (>=1; bench uses 4)
END_CODE, 8'hFF, byte value that terminates playback (not played)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begin playback at address 0
stop  input  1  one-cycle pulse; abort playback
mem_read_en  output  1  read strobe to note memory (registered)
mem_write_en  output  1  constant 0
mem_addr  output  ADDR_W  read address (registered)
mem_data  input  DATA_W  memory data_out; valid only the cycle after mem_read_en=1
note_out  output  DATA_W  current note code to tone generator; 0 = silence
note_valid  output  1  one-cycle pulse when note_out takes a new tape byte
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when playback ends normally

Behaviour:
- Reset (sampled on a clk edge with rst=1): state=IDLE; mem_read_en=0, mem_addr=0, note_out=0, note_valid=0, busy=0, done=0; hold counter=0. Reset overrides all inputs and aborts any playback.
- State IDLE: start=1 and stop=0 -> mem_addr<=0, mem_read_en<=1, go FETCH. Otherwise stay.
- State FETCH (one cycle): mem_read_en=1 during this cycle. Next edge: mem_read_en<=0, go CAPTURE.
- State CAPTURE (one cycle): mem_data is valid.
  - mem_data==END_CODE -> note_out<=0, done<=1, go IDLE.
  - Otherwise -> note_out<=mem_data, note_valid<=1, counter<=0, go HOLD.
- State HOLD: counter increments each cycle.
  - When counter==TICKS_PER_STEP-1 and mem_addr==2^ADDR_W-1: note_out<=0, done<=1, go IDLE. There is no wrap.
  - When counter==TICKS_PER_STEP-1 otherwise: mem_addr<=mem_addr+1, mem_read_en<=1, go FETCH.
- Timing:
  - Latency from the start edge to note_valid high is 3 clk edges.
  - Step period is TICKS_PER_STEP+2 cycles.
  - note_out keeps the previous note through FETCH/CAPTURE, so playback has no audible gap.
- Byte 0x00 is a rest: it is played as silence and still pulses note_valid.
- stop=1 in any non-IDLE state: next edge go IDLE, note_out<=0, mem_read_en<=0; done stays 0.
- start and stop together: stop wins.
- start while busy: ignored.
- note_valid and done are single-cycle pulses. They are never high in the same cycle.

Test Plan:
1. Reset check: assert rst for 2 cycles mid-HOLD -> next cycle all outputs 0, state IDLE; a subsequent start replays from addr 0.
2. Basic playback: mem[0..3]={0x11,0x22,0x00,0xFF}, TICKS_PER_STEP=4, pulse start.
   - note_valid at edges 3, 9, 15 with note_out 0x11, 0x22, 0x00.
   - done pulse at edge 21 with note_out=0; mem_read_en is high exactly 4 cycles total.
3. Read protocol: monitor strobes -> mem_write_en never 1; mem_addr stable while mem_read_en=1; note_out equals mem[addr] from the read issued one cycle earlier.
4. Stop mid-note: stop during 2nd HOLD -> next cycle note_out=0, busy=0, no done; start+stop same cycle in IDLE -> stays IDLE.
5. Full tape: all 1024 bytes 0x01, no END_CODE -> 1024 note_valid pulses, done after addr 1023 hold, mem_addr never wraps to 0 during playback.
